// File: rtl/bitcell_array_ctrl.sv
// Access sequencer for the 8x8 bitcell array: turns a req/ack transaction into
// row select, write strobe and column data waveforms, and captures read data.
module bitcell_array_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int WR_CYC = 2,
    parameter int RD_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata,
    output logic                 ack,
    output logic                 busy,
    output logic [2**ADDR_W-1:0] row_sel,
    output logic                 rw,
    output logic [DATA_W-1:0]    col_in,
    input  logic [DATA_W-1:0]    col_out
);

    localparam int ROWS  = 2**ADDR_W;
    localparam int CMAX  = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int CNT_W = (CMAX < 2) ? 1 : $clog2(CMAX);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_reg,   state_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic              we_reg,      we_next;
    logic [ROWS-1:0]   row_sel_reg, row_sel_next;
    logic              rw_reg,      rw_next;
    logic [DATA_W-1:0] col_in_reg,  col_in_next;
    logic [DATA_W-1:0] rdata_reg,   rdata_next;
    logic              ack_reg,     ack_next;
    logic              busy_reg,    busy_next;
    logic [ROWS-1:0]   addr_onehot;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_dec
            assign addr_onehot[gi] = (addr == ADDR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        we_next      = we_reg;
        row_sel_next = row_sel_reg;
        rw_next      = rw_reg;
        col_in_next  = col_in_reg;
        rdata_next   = rdata_reg;
        ack_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    state_next   = S_SETUP;
                    we_next      = we;
                    row_sel_next = addr_onehot;
                    col_in_next  = we ? wdata : '0;
                    rw_next      = 1'b0;
                    cnt_next     = we ? CNT_W'(WR_CYC - 1) : CNT_W'(RD_CYC - 1);
                end
            end
            S_SETUP: begin
                // rw rises one cycle after row_sel so the select is settled first
                state_next = we_reg ? S_WRITE : S_READ;
                rw_next    = we_reg;
            end
            S_WRITE: begin
                if (cnt_reg == '0) begin
                    state_next = S_HOLD;
                    rw_next    = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_HOLD: begin
                state_next   = S_DONE;
                ack_next     = 1'b1;
                row_sel_next = '0;
                col_in_next  = '0;
            end
            S_READ: begin
                if (cnt_reg == '0) begin
                    state_next   = S_DONE;
                    rdata_next   = col_out;
                    ack_next     = 1'b1;
                    row_sel_next = '0;
                    col_in_next  = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next   = S_IDLE;
                row_sel_next = '0;
                rw_next      = 1'b0;
                col_in_next  = '0;
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            row_sel_reg <= '0;
            rw_reg      <= 1'b0;
            col_in_reg  <= '0;
            rdata_reg   <= '0;
            ack_reg     <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            we_reg      <= we_next;
            row_sel_reg <= row_sel_next;
            rw_reg      <= rw_next;
            col_in_reg  <= col_in_next;
            rdata_reg   <= rdata_next;
            ack_reg     <= ack_next;
            busy_reg    <= busy_next;
        end
    end

    assign row_sel = row_sel_reg;
    assign rw      = rw_reg;
    assign col_in  = col_in_reg;
    assign rdata   = rdata_reg;
    assign ack     = ack_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Directed-vector bench for bitcell_array_ctrl with a behavioural 8x8 array model.
module tb_bitcell_array_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;
    logic [7:0] row_sel;
    logic       rw;
    logic [7:0] col_in;
    logic [7:0] col_out;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    int rw_cnt = 0;
    int cyc = 0;
    logic [7:0] mem [8];

    always #5 clk = ~clk;

    bitcell_array_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .row_sel(row_sel), .rw(rw),
        .col_in(col_in), .col_out(col_out)
    );

    // Array model: selected rows store col_in while rw is high; col_out ORs selected rows
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 8; r++)
            if (row_sel[r]) col_out = col_out | mem[r];
    end

    always @(posedge clk) begin
        for (int r = 0; r < 8; r++)
            if (rw && row_sel[r]) mem[r] <= col_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (ack) ack_cnt++;
            if (rw) rw_cnt++;
            chk("rw_implies_sel", 32'(rw && (row_sel == 8'h00)), 32'd0);
            chk("sel_onehot0", 32'($onehot0(row_sel)), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        while (!ack && lat < 12) begin
            step();
            lat++;
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        int lat;
        ack_cnt = 0;
        rw_cnt = 0;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        step();
        req = 1'b0;
        chk("wr_setup_sel", 32'(row_sel), 32'(8'h01 << a));
        chk("wr_setup_col", 32'(col_in), 32'(d));
        chk("wr_setup_rw", 32'(rw), 32'd0);
        wait_ack(lat);
        chk("wr_latency", 32'(lat), 32'd4);
        step();
        chk("wr_idle_busy", 32'(busy), 32'd0);
        chk("wr_ack_count", 32'(ack_cnt), 32'd1);
        chk("wr_rw_cycles", 32'(rw_cnt), 32'd2);
        $display("write addr=%0d data=%h lat=%0d acks=%0d rw_cycles=%0d", a, d, lat, ack_cnt, rw_cnt);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] exp);
        int lat;
        ack_cnt = 0;
        rw_cnt = 0;
        req = 1'b1; we = 1'b0; addr = a; wdata = 8'hFF;
        step();
        req = 1'b0;
        chk("rd_setup_sel", 32'(row_sel), 32'(8'h01 << a));
        chk("rd_setup_col", 32'(col_in), 32'd0);
        wait_ack(lat);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_data", 32'(rdata), 32'(exp));
        chk("rd_done_sel", 32'(row_sel), 32'd0);
        step();
        chk("rd_ack_count", 32'(ack_cnt), 32'd1);
        chk("rd_rw_cycles", 32'(rw_cnt), 32'd0);
        $display("read addr=%0d data=%h exp=%h lat=%0d", a, rdata, exp, lat);
    endtask

    initial begin
        int t0, t1, t2, n;
        for (int r = 0; r < 8; r++) mem[r] = 8'h00;

        // 1. reset
        rst = 1'b1;
        step(); step();
        chk("rst_row_sel", 32'(row_sel), 32'd0);
        chk("rst_rw", 32'(rw), 32'd0);
        chk("rst_col_in", 32'(col_in), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        $display("reset released busy=%0d row_sel=%h", busy, row_sel);

        // 2. write addr 3
        do_write(3'd3, 8'hA5);

        // 5. reset during the second rw cycle of a write
        ack_cnt = 0;
        req = 1'b1; we = 1'b1; addr = 3'd5; wdata = 8'h3C;
        step();
        req = 1'b0;
        step();
        chk("abort_rw_first", 32'(rw), 32'd1);
        step();
        chk("abort_rw_second", 32'(rw), 32'd1);
        rst = 1'b1;
        step();
        chk("abort_rw", 32'(rw), 32'd0);
        chk("abort_row_sel", 32'(row_sel), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        step(); step(); step();
        chk("abort_no_ack", 32'(ack_cnt), 32'd0);
        $display("abort write addr=5 acks=%0d busy=%0d", ack_cnt, busy);

        // 3. read back addr 3
        do_read(3'd3, 8'hA5);

        // 4a. req pulsed while busy is ignored
        ack_cnt = 0;
        req = 1'b1; we = 1'b1; addr = 3'd6; wdata = 8'h11;
        step();
        req = 1'b0;
        step();
        req = 1'b1; we = 1'b1; addr = 3'd7; wdata = 8'h22;
        step();
        req = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("busy_req_acks", 32'(ack_cnt), 32'd1);
        chk("busy_req_row7", 32'(mem[7]), 32'd0);
        $display("ignored req during busy acks=%0d mem6=%h mem7=%h", ack_cnt, mem[6], mem[7]);

        // 4b. req held high: reads back-to-back, one IDLE cycle between
        req = 1'b1; we = 1'b0; addr = 3'd3;
        t0 = -1; t1 = -1; t2 = -1; n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            step();
            if (ack) begin
                if (n == 0) t0 = cyc; else if (n == 1) t1 = cyc; else t2 = cyc;
                n++;
            end
        end
        req = 1'b0;
        chk("b2b_acks", 32'(n), 32'd3);
        chk("b2b_gap1", 32'(t1 - t0), 32'd4);
        chk("b2b_gap2", 32'(t2 - t1), 32'd4);
        for (int i = 0; i < 6; i++) step();
        $display("held req ack cycles %0d %0d %0d", t0, t1, t2);

        // 6. sweep all rows
        for (int a = 0; a < 8; a++) do_write(3'(a), 8'hFF ^ 8'(a));
        for (int a = 0; a < 8; a++) do_read(3'(a), 8'hFF ^ 8'(a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
